// File: rtl/hit_monit_multi.sv
// Multi-slot hit-rate monitor: counts rising edges on selectable hit channels per rd_in window.
// Latency: latched counts and cnt_valid_out appear one cycle after rd_in rises.
// No backpressure: cnt_valid_out is a one-cycle pulse; readers must capture on that pulse.
module hit_monit_multi #(
    parameter int HIT_WIDTH    = 13,
    parameter int MONIT_NUM    = 4,
    parameter int SEL_WIDTH    = 4,
    parameter int CNT_WIDTH    = 16,
    parameter int ERR_WIDTH    = 8,
    parameter int STUCK_CYCLES = 64
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           rd_in,
    input  logic [HIT_WIDTH-1:0]           hit_syn_in,
    input  logic [MONIT_NUM*SEL_WIDTH-1:0] monit_fix_sel_in,
    input  logic                           auto_scan_in,
    output logic [MONIT_NUM*SEL_WIDTH-1:0] hit_monit_sel_out,
    output logic [MONIT_NUM*CNT_WIDTH-1:0] hit_monit_cnt_out,
    output logic [ERR_WIDTH-1:0]           hit_monit_err_cnt_out,
    output logic                           cnt_valid_out
);

    localparam int RUN_W = $clog2(STUCK_CYCLES + 1);
    localparam int EVT_W = $clog2(2 * MONIT_NUM + 1);
    localparam int SUM_W = ERR_WIDTH + EVT_W;
    localparam int PAD_W = 2 ** SEL_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;
    localparam logic [RUN_W-1:0]     RUN_MAX = RUN_W'(STUCK_CYCLES);
    localparam logic [RUN_W-1:0]     RUN_ARM = RUN_W'(STUCK_CYCLES - 1);

    logic [HIT_WIDTH-1:0] hit_q;
    logic                 rd_q;
    logic                 win_end;
    logic [PAD_W-1:0]     edge_pad;
    logic [PAD_W-1:0]     lvl_pad;

    logic [SEL_WIDTH-1:0] act_sel  [MONIT_NUM];
    logic [SEL_WIDTH-1:0] sel_nxt  [MONIT_NUM];
    logic [CNT_WIDTH-1:0] live     [MONIT_NUM];
    logic [CNT_WIDTH-1:0] live_inc [MONIT_NUM];
    logic [RUN_W-1:0]     run      [MONIT_NUM];
    logic [RUN_W-1:0]     run_nxt  [MONIT_NUM];

    logic [EVT_W-1:0]     err_events;
    logic [SUM_W-1:0]     err_sum;

    // A window closes only on the rising edge of rd_in; a held strobe does not retrigger.
    assign win_end = rd_in & ~rd_q;

    // Previous levels are kept for every channel so re-selection never fakes an edge.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hit_q <= '0;
            rd_q  <= 1'b0;
        end else begin
            hit_q <= hit_syn_in;
            rd_q  <= rd_in;
        end
    end

    // Pad edges/levels to the full selector range so out-of-range selectors read as zero.
    always_comb begin
        edge_pad                  = '0;
        lvl_pad                   = '0;
        edge_pad[HIT_WIDTH-1:0]   = hit_syn_in & ~hit_q;
        lvl_pad[HIT_WIDTH-1:0]    = hit_syn_in;
    end

    // Per-slot next state: saturating count, next selection, stuck run length and error events.
    always_comb begin
        logic                 sel_ok;
        logic                 slot_edge;
        logic                 slot_lvl;
        logic                 stuck_evt;
        logic [SEL_WIDTH-1:0] nsel;
        logic [RUN_W-1:0]     nrun;
        sel_ok     = 1'b0;
        slot_edge  = 1'b0;
        slot_lvl   = 1'b0;
        stuck_evt  = 1'b0;
        nsel       = '0;
        nrun       = '0;
        err_events = '0;
        for (int k = 0; k < MONIT_NUM; k++) begin
            sel_ok    = int'(act_sel[k]) < HIT_WIDTH;
            slot_edge = edge_pad[act_sel[k]];
            slot_lvl  = lvl_pad[act_sel[k]];

            if (slot_edge && (live[k] != CNT_MAX)) begin
                live_inc[k] = live[k] + CNT_WIDTH'(1);
            end else begin
                live_inc[k] = live[k];
            end

            if (auto_scan_in) begin
                nsel = SEL_WIDTH'((int'(act_sel[k]) + MONIT_NUM) % HIT_WIDTH);
            end else begin
                nsel = monit_fix_sel_in[k*SEL_WIDTH +: SEL_WIDTH];
            end
            sel_nxt[k] = nsel;

            // The event fires on the cycle the run first reaches the threshold, even if
            // the selection moves away on that same boundary.
            stuck_evt = slot_lvl && (run[k] == RUN_ARM);
            if (!slot_lvl) begin
                nrun = '0;
            end else if (run[k] == RUN_MAX) begin
                nrun = RUN_MAX;
            end else begin
                nrun = run[k] + RUN_W'(1);
            end
            if (win_end && (nsel != act_sel[k])) begin
                nrun = '0;
            end
            run_nxt[k] = nrun;

            err_events = err_events + EVT_W'(stuck_evt) + EVT_W'(win_end && !sel_ok);
        end
    end

    assign err_sum = SUM_W'(hit_monit_err_cnt_out) + SUM_W'(err_events);

    // Live slot state: counters clear and selections advance only at a window boundary.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int k = 0; k < MONIT_NUM; k++) begin
                act_sel[k] <= SEL_WIDTH'(k);
                live[k]    <= '0;
                run[k]     <= '0;
            end
        end else begin
            for (int k = 0; k < MONIT_NUM; k++) begin
                run[k] <= run_nxt[k];
                if (win_end) begin
                    live[k]    <= '0;
                    act_sel[k] <= sel_nxt[k];
                end else begin
                    live[k]    <= live_inc[k];
                end
            end
        end
    end

    // Latch the closing window (including a same-cycle edge) and its selections.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_valid_out     <= 1'b0;
            hit_monit_cnt_out <= '0;
            for (int k = 0; k < MONIT_NUM; k++) begin
                hit_monit_sel_out[k*SEL_WIDTH +: SEL_WIDTH] <= SEL_WIDTH'(k);
            end
        end else begin
            cnt_valid_out <= win_end;
            if (win_end) begin
                for (int k = 0; k < MONIT_NUM; k++) begin
                    hit_monit_cnt_out[k*CNT_WIDTH +: CNT_WIDTH] <= live_inc[k];
                    hit_monit_sel_out[k*SEL_WIDTH +: SEL_WIDTH] <= act_sel[k];
                end
            end
        end
    end

    // Cumulative error events, saturating; only reset clears it.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hit_monit_err_cnt_out <= '0;
        end else if (err_sum > SUM_W'(ERR_MAX)) begin
            hit_monit_err_cnt_out <= ERR_MAX;
        end else begin
            hit_monit_err_cnt_out <= err_sum[ERR_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_hit_monit_multi.sv
// Bench for hit_monit_multi: directed scenarios plus randomized windows against a channel-level model.
// Two instances share stimulus: 16-bit and 4-bit counters, to exercise count saturation.
// Inputs change 1 ns after the rising edge; outputs are compared 1 ns after the rising edge.
module tb_hit_monit_multi;

    localparam int HW    = 13;
    localparam int MN    = 4;
    localparam int SW    = 4;
    localparam int STUCK = 64;

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b0;
    logic            rd_in = 1'b0;
    logic [HW-1:0]   hit_syn_in = '0;
    logic [MN*SW-1:0] monit_fix_sel_in = '0;
    logic            auto_scan_in = 1'b0;

    logic [MN*SW-1:0] sel_out, sel_out_s;
    logic [MN*16-1:0] cnt_out;
    logic [MN*4-1:0]  cnt_out_s;
    logic [7:0]       err_out, err_out_s;
    logic             vld_out, vld_out_s;

    int n_tests = 0;
    int n_fail  = 0;

    hit_monit_multi #(.HIT_WIDTH(HW), .MONIT_NUM(MN), .SEL_WIDTH(SW), .CNT_WIDTH(16),
                      .ERR_WIDTH(8), .STUCK_CYCLES(STUCK)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rd_in(rd_in), .hit_syn_in(hit_syn_in),
        .monit_fix_sel_in(monit_fix_sel_in), .auto_scan_in(auto_scan_in),
        .hit_monit_sel_out(sel_out), .hit_monit_cnt_out(cnt_out),
        .hit_monit_err_cnt_out(err_out), .cnt_valid_out(vld_out));

    hit_monit_multi #(.HIT_WIDTH(HW), .MONIT_NUM(MN), .SEL_WIDTH(SW), .CNT_WIDTH(4),
                      .ERR_WIDTH(8), .STUCK_CYCLES(STUCK)) dut_s (
        .clk_in(clk_in), .rst_in(rst_in), .rd_in(rd_in), .hit_syn_in(hit_syn_in),
        .monit_fix_sel_in(monit_fix_sel_in), .auto_scan_in(auto_scan_in),
        .hit_monit_sel_out(sel_out_s), .hit_monit_cnt_out(cnt_out_s),
        .hit_monit_err_cnt_out(err_out_s), .cnt_valid_out(vld_out_s));

    always #5 clk_in = ~clk_in;

    // Reference model: edges counted per channel over the whole window; slots just look up.
    int           m_chan    [HW];
    logic [HW-1:0] m_prev_hit;
    logic         m_prev_rd;
    int           m_sel     [MN];
    int           m_run     [MN];
    int           m_out_sel [MN];
    int           m_out_cnt [MN];
    int           m_err;
    logic         m_vld;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < HW; c++) m_chan[c] = 0;
        for (int k = 0; k < MN; k++) begin
            m_sel[k] = k; m_run[k] = 0; m_out_sel[k] = k; m_out_cnt[k] = 0;
        end
        m_prev_hit = '0; m_prev_rd = 1'b0; m_err = 0; m_vld = 1'b0;
    endtask

    task automatic model_step();
        int   ev;
        int   nsel;
        logic bnd;
        ev  = 0;
        bnd = rd_in && !m_prev_rd;
        for (int c = 0; c < HW; c++)
            if (hit_syn_in[c] && !m_prev_hit[c]) m_chan[c]++;
        for (int k = 0; k < MN; k++) begin
            if (m_sel[k] < HW) begin
                if (hit_syn_in[m_sel[k]]) begin
                    m_run[k]++;
                    if (m_run[k] == STUCK) ev++;
                end else begin
                    m_run[k] = 0;
                end
            end else begin
                m_run[k] = 0;
            end
        end
        m_vld = bnd;
        if (bnd) begin
            for (int k = 0; k < MN; k++) begin
                m_out_sel[k] = m_sel[k];
                if (m_sel[k] < HW) m_out_cnt[k] = m_chan[m_sel[k]];
                else begin
                    m_out_cnt[k] = 0;
                    ev++;
                end
                if (auto_scan_in) nsel = (m_sel[k] + MN) % HW;
                else nsel = int'(monit_fix_sel_in[k*SW +: SW]);
                if (nsel != m_sel[k]) m_run[k] = 0;
                m_sel[k] = nsel;
            end
            for (int c = 0; c < HW; c++) m_chan[c] = 0;
        end
        m_err = (m_err + ev > 255) ? 255 : m_err + ev;
        m_prev_hit = hit_syn_in;
        m_prev_rd  = rd_in;
    endtask

    task automatic compare_all();
        logic [63:0] ec;
        logic [15:0] ecs;
        logic [15:0] es;
        for (int k = 0; k < MN; k++) begin
            ec[k*16 +: 16] = (m_out_cnt[k] > 65535) ? 16'hFFFF : 16'(m_out_cnt[k]);
            ecs[k*4 +: 4]  = (m_out_cnt[k] > 15) ? 4'hF : 4'(m_out_cnt[k]);
            es[k*4 +: 4]   = 4'(m_out_sel[k]);
        end
        check("vld16", {63'd0, vld_out}, {63'd0, m_vld});
        check("vld4", {63'd0, vld_out_s}, {63'd0, m_vld});
        check("sel16", {48'd0, sel_out}, {48'd0, es});
        check("sel4", {48'd0, sel_out_s}, {48'd0, es});
        check("cnt16", cnt_out, ec);
        check("cnt4", {48'd0, cnt_out_s}, {48'd0, ecs});
        check("err16", {56'd0, err_out}, 64'(m_err));
        check("err4", {56'd0, err_out_s}, 64'(m_err));
    endtask

    // One clock: advance the model on the inputs about to be sampled, then compare.
    task automatic cyc();
        if (rst_in) model_reset();
        else model_step();
        @(posedge clk_in);
        #1;
        if (!rst_in) compare_all();
    endtask

    task automatic check_reset();
        check("rst_vld", {63'd0, vld_out}, 64'd0);
        check("rst_sel", {48'd0, sel_out}, 64'h3210);
        check("rst_cnt", cnt_out, 64'd0);
        check("rst_err", {56'd0, err_out}, 64'd0);
        check("rst_cnt4", {48'd0, cnt_out_s}, 64'd0);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        model_reset();
        #1;
        check_reset();
        cyc();
        cyc();
        rst_in = 1'b0;
        rd_in = 1'b0;
        hit_syn_in = '0;
    endtask

    task automatic pulse(input int ch);
        hit_syn_in[ch] = 1'b1;
        cyc();
        hit_syn_in[ch] = 1'b0;
        cyc();
    endtask

    task automatic load_sel(input logic [MN*SW-1:0] fix);
        monit_fix_sel_in = fix;
        auto_scan_in = 1'b0;
        rd_in = 1'b1;
        cyc();
        rd_in = 1'b0;
        cyc();
    endtask

    initial begin
        logic [15:0]   scan_exp [4];
        logic [HW-1:0] h;
        int            len, hold_ch, rdlen;

        #2;
        do_reset();

        // Fixed selection {7,12,4,0}: 5 edges on ch7, 3 on ch12.
        load_sel(16'h04C7);
        for (int i = 0; i < 5; i++) begin
            hit_syn_in[7] = 1'b1;
            if (i < 3) hit_syn_in[12] = 1'b1;
            cyc();
            hit_syn_in = '0;
            cyc();
        end
        rd_in = 1'b1;
        cyc();
        check("fix_vld", {63'd0, vld_out}, 64'd1);
        check("fix_cnt", cnt_out, 64'h0000_0000_0003_0005);
        check("fix_sel", {48'd0, sel_out}, 64'h04C7);
        rd_in = 1'b0;
        cyc();
        check("fix_vld_drop", {63'd0, vld_out}, 64'd0);

        // Auto-scan rotation with wrap at HIT_WIDTH.
        do_reset();
        scan_exp[0] = 16'h3210; scan_exp[1] = 16'h7654;
        scan_exp[2] = 16'hBA98; scan_exp[3] = 16'h210C;
        auto_scan_in = 1'b1;
        for (int w = 0; w < 4; w++) begin
            rd_in = 1'b1;
            cyc();
            check("scan_sel", {48'd0, sel_out}, {48'd0, scan_exp[w]});
            rd_in = 1'b0;
            cyc();
        end

        // Invalid selector 14 on slot 2.
        do_reset();
        load_sel(16'h3E10);
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 2; i++) begin
                hit_syn_in = '1;
                cyc();
                hit_syn_in = '0;
                cyc();
            end
            rd_in = 1'b1;
            cyc();
            check("inv_cnt", cnt_out, 64'h0002_0000_0002_0002);
            check("inv_err", {56'd0, err_out}, 64'(w + 1));
            rd_in = 1'b0;
            cyc();
        end

        // Channel 9 held high for 200 cycles.
        do_reset();
        load_sel(16'h3219);
        hit_syn_in[9] = 1'b1;
        for (int i = 0; i < 200; i++) cyc();
        hit_syn_in[9] = 1'b0;
        cyc();
        rd_in = 1'b1;
        cyc();
        check("stuck_cnt", cnt_out, 64'd1);
        check("stuck_err", {56'd0, err_out}, 64'd1);
        rd_in = 1'b0;
        cyc();

        // 20 edges in one window, the last in the boundary cycle.
        do_reset();
        load_sel(16'h3217);
        for (int i = 0; i < 19; i++) pulse(7);
        hit_syn_in[7] = 1'b1;
        rd_in = 1'b1;
        cyc();
        check("sat_cnt4", {48'd0, cnt_out_s}, 64'h000F);
        check("sat_cnt16", cnt_out, 64'd20);
        hit_syn_in = '0;
        rd_in = 1'b0;
        cyc();
        pulse(7);
        rd_in = 1'b1;
        cyc();
        check("next_cnt4", {48'd0, cnt_out_s}, 64'd1);
        check("next_cnt16", cnt_out, 64'd1);
        rd_in = 1'b0;
        cyc();

        // Reset mid-window after 6 counted edges.
        for (int i = 0; i < 6; i++) pulse(7);
        do_reset();
        pulse(0);
        pulse(0);
        rd_in = 1'b1;
        cyc();
        check("post_rst_cnt", cnt_out, 64'd2);
        check("post_rst_sel", {48'd0, sel_out}, 64'h3210);
        rd_in = 1'b0;
        cyc();

        // Randomized windows, including invalid selectors and long high runs.
        for (int w = 0; w < 80; w++) begin
            monit_fix_sel_in = 16'($urandom);
            auto_scan_in = 1'($urandom_range(0, 1));
            len = $urandom_range(2, 150);
            hold_ch = $urandom_range(0, 20);
            rd_in = 1'b0;
            for (int i = 0; i < len; i++) begin
                h = HW'($urandom & $urandom & $urandom);
                if (hold_ch < HW) h[hold_ch] = 1'b1;
                hit_syn_in = h;
                cyc();
            end
            rdlen = $urandom_range(1, 3);
            for (int i = 0; i < rdlen; i++) begin
                h = HW'($urandom & $urandom);
                if (hold_ch < HW) h[hold_ch] = 1'b1;
                hit_syn_in = h;
                rd_in = 1'b1;
                cyc();
            end
        end
        rd_in = 1'b0;
        hit_syn_in = '0;
        cyc();

        // Error counter saturation: all slots invalid for many windows.
        do_reset();
        load_sel(16'hFFFF);
        for (int w = 0; w < 69; w++) begin
            rd_in = 1'b1;
            cyc();
            rd_in = 1'b0;
            cyc();
        end
        check("err_sat16", {56'd0, err_out}, 64'd255);
        check("err_sat4", {56'd0, err_out_s}, 64'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
